// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: bus payloads, load opcodes and FSM states.
package mem_stage_pkg;

    localparam int unsigned ES_TO_MS_W = 83;
    localparam int unsigned MS_TO_WS_W = 79;
    localparam int unsigned DATA_W     = 32;

    localparam logic [2:0] LOAD_NONE = 3'd0;
    localparam logic [2:0] LOAD_B    = 3'd1;
    localparam logic [2:0] LOAD_BU   = 3'd2;
    localparam logic [2:0] LOAD_H    = 3'd3;
    localparam logic [2:0] LOAD_HU   = 3'd4;
    localparam logic [2:0] LOAD_W    = 3'd5;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_HOLD = 2'd2
    } ms_state_e;

    typedef struct packed {
        logic              ex;
        logic              bd;
        logic              eret;
        logic              syscall;
        logic              mfc0;
        logic              mtc0;
        logic [3:0]        gr_strb;
        logic [4:0]        dest;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] pc;
        logic [2:0]        load_op;
        logic              mem_req;
    } es_to_ms_t;

    typedef struct packed {
        logic              ex;
        logic              bd;
        logic              eret;
        logic              syscall;
        logic              mfc0;
        logic              mtc0;
        logic [3:0]        gr_strb;
        logic [4:0]        dest;
        logic [DATA_W-1:0] final_result;
        logic [DATA_W-1:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: picks the addressed byte/half from a load word and extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        offset_i,
    input  logic [2:0]        load_op_i,
    output logic [DATA_W-1:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rdata_i >> {offset_i, 3'b000});
        half_sel = 16'(rdata_i >> {offset_i[1], 4'b0000});
        case (load_op_i)
            LOAD_B:  result_o = {{24{byte_sel[7]}}, byte_sel};
            LOAD_BU: result_o = {24'd0, byte_sel};
            LOAD_H:  result_o = {{16{half_sel[15]}}, half_sel};
            LOAD_HU: result_o = {16'd0, half_sel};
            // lw, and the reserved encodings, return the whole word
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one EX result, waits for load data, aligns it and hands off to WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ES_TO_MS_BUS_WD = ES_TO_MS_W,
    parameter int unsigned MS_TO_WS_BUS_WD = MS_TO_WS_W
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [DATA_W-1:0]          data_sram_rdata,
    input  logic                       flush,
    output logic [4:0]                 ms_rf_dest,
    output logic                       ms_inst_mfc0_o
);

    es_to_ms_t         es_in;
    es_to_ms_t         bus_q;
    ms_to_ws_t         ws_out;
    ms_state_e         state_q, state_d;
    logic              ms_valid_q, ms_valid_d;
    logic              cancel_q, cancel_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic              own_ok;
    logic              discard;
    logic              ms_ready_go;
    logic              accept;
    logic              leaving;
    logic              cur_load;
    logic              cur_load_waiting;
    logic              proto_err_c;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] aligned;

    assign es_in = es_to_ms_bus;

    // a response belongs to the resident load only once any cancelled one has drained
    assign own_ok           = (state_q == MS_WAIT) && data_sram_data_ok && !cancel_q;
    assign discard          = data_sram_data_ok && cancel_q;
    assign ms_ready_go      = !bus_q.mem_req || (state_q == MS_HOLD) || own_ok;
    assign ms_allowin       = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid   = ms_valid_q && ms_ready_go && !flush;
    assign accept           = es_to_ms_valid && ms_allowin && !flush;
    assign leaving          = ms_valid_q && ms_ready_go && ws_allowin;
    assign cur_load         = ms_valid_q && bus_q.mem_req;
    assign cur_load_waiting = cur_load && (state_q == MS_WAIT) && !own_ok;
    assign proto_err_c      = data_sram_data_ok && (state_q == MS_IDLE) && !cancel_q;

    // next-state logic for the load FSM, cancel flag, hold register and valid bit
    always_comb begin
        state_d    = state_q;
        cancel_d   = cancel_q;
        hold_d     = hold_q;
        ms_valid_d = ms_valid_q;

        if (ms_allowin) ms_valid_d = es_to_ms_valid;
        if (flush)      ms_valid_d = 1'b0;

        if (own_ok) hold_d = data_sram_rdata;

        if (flush && cur_load_waiting) cancel_d = 1'b1;
        else if (discard)              cancel_d = 1'b0;

        if (flush) begin
            state_d = cancel_d ? MS_WAIT : MS_IDLE;
        end else if (accept && es_in.mem_req) begin
            state_d = MS_WAIT;
        end else if (cur_load && !leaving) begin
            state_d = (own_ok || state_q == MS_HOLD) ? MS_HOLD : MS_WAIT;
        end else begin
            state_d = cancel_d ? MS_WAIT : MS_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= MS_IDLE;
            cancel_q   <= 1'b0;
            hold_q     <= '0;
            ms_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cancel_q   <= cancel_d;
            hold_q     <= hold_d;
            ms_valid_q <= ms_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) bus_q <= es_in;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!proto_err_c)
                else $warning("mem_stage: data_ok with no load outstanding, ignored");
        end
    end

    assign load_word = (state_q == MS_HOLD) ? hold_q : data_sram_rdata;

    load_align u_load_align (
        .rdata_i   (load_word),
        .offset_i  (bus_q.alu_result[1:0]),
        .load_op_i (bus_q.load_op),
        .result_o  (aligned)
    );

    always_comb begin
        ws_out.ex           = bus_q.ex;
        ws_out.bd           = bus_q.bd;
        ws_out.eret         = bus_q.eret;
        ws_out.syscall      = bus_q.syscall;
        ws_out.mfc0         = bus_q.mfc0;
        ws_out.mtc0         = bus_q.mtc0;
        ws_out.gr_strb      = bus_q.gr_strb;
        ws_out.dest         = bus_q.dest;
        ws_out.final_result = (bus_q.load_op == LOAD_NONE) ? bus_q.alu_result : aligned;
        ws_out.pc           = bus_q.pc;
    end

    assign ms_to_ws_bus   = ws_out;
    assign ms_rf_dest     = (ms_valid_q && (bus_q.gr_strb != 4'd0)) ? bus_q.dest : 5'd0;
    assign ms_inst_mfc0_o = ms_valid_q && bus_q.mfc0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a transaction-level model of the stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [82:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [78:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        flush;
    logic [4:0]  ms_rf_dest;
    logic        ms_inst_mfc0_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .flush             (flush),
        .ms_rf_dest        (ms_rf_dest),
        .ms_inst_mfc0_o    (ms_inst_mfc0_o)
    );

    task automatic chk(input string tag, input logic [78:0] obs, input logic [78:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [82:0] mk(input logic [5:0] flags, input logic [3:0] strb,
                                       input logic [4:0] dest, input logic [31:0] alu,
                                       input logic [31:0] pc, input logic [2:0] op,
                                       input logic req);
        return {flags, strb, dest, alu, pc, op, req};
    endfunction

    // architectural load result from the word, the byte offset and the opcode
    function automatic logic [31:0] ld_result(input logic [2:0] op, input logic [31:0] alu,
                                              input logic [31:0] rd);
        int unsigned off;
        logic [31:0] b;
        logic [31:0] h;
        off = int'(alu % 4);
        b = (rd >> (8 * off)) & 32'hFF;
        h = (rd >> (16 * (off / 2))) & 32'hFFFF;
        case (op)
            3'd0:    return alu;
            3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [78:0] out_bus(input logic [82:0] e, input logic [31:0] fin);
        return {e[82:77], e[76:73], e[72:68], fin, e[35:4]};
    endfunction

    logic [82:0] m_bus;
    logic        m_valid, m_have, pend;
    logic [31:0] m_final;
    int          dly;
    logic        ev, ea, r_req;
    logic [2:0]  r_op;
    logic [31:0] fin;

    initial begin
        resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; flush = 1'b0;
        tick(); tick();
        chk("rst_valid",   79'(ms_to_ws_valid), 79'(0));
        chk("rst_allowin", 79'(ms_allowin),     79'(1));
        chk("rst_dest",    79'(ms_rf_dest),     79'(0));
        chk("rst_mfc0",    79'(ms_inst_mfc0_o), 79'(0));
        resetn = 1'b1;

        // ALU op passes straight through
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(6'b0, 4'hF, 5'd5, 32'h1234, 32'hBFC0_0000, 3'd0, 1'b0);
        #1 chk("alu_allowin", 79'(ms_allowin), 79'(1));
        tick(); es_to_ms_valid = 1'b0; #1;
        chk("alu_valid", 79'(ms_to_ws_valid), 79'(1));
        chk("alu_bus", ms_to_ws_bus,
            out_bus(mk(6'b0, 4'hF, 5'd5, 32'h1234, 32'hBFC0_0000, 3'd0, 1'b0), 32'h1234));
        chk("alu_dest", 79'(ms_rf_dest), 79'(5));
        tick(); #1 chk("alu_drain", 79'(ms_to_ws_valid), 79'(0));

        // lb at offset 3 with data two cycles late
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(6'b000010, 4'h0, 5'd7, 32'h1003, 32'hBFC0_0004, 3'd1, 1'b1);
        tick(); es_to_ms_valid = 1'b0; #1;
        chk("lb_stall1",  79'(ms_to_ws_valid), 79'(0));
        chk("lb_allowin", 79'(ms_allowin),     79'(0));
        chk("lb_mfc0",    79'(ms_inst_mfc0_o), 79'(1));
        chk("lb_dest",    79'(ms_rf_dest),     79'(0));
        tick(); #1 chk("lb_stall2", 79'(ms_to_ws_valid), 79'(0));
        tick(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_FF7F; #1;
        chk("lb_valid",  79'(ms_to_ws_valid),       79'(1));
        chk("lb_result", 79'(ms_to_ws_bus[63:32]), 79'(32'hFFFF_FF80));
        tick(); data_sram_data_ok = 1'b0; #1 chk("lb_done", 79'(ms_to_ws_valid), 79'(0));

        // lhu at offset 2 while WB stalls for three cycles
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(6'b0, 4'hF, 5'd9, 32'h2002, 32'hBFC0_0008, 3'd4, 1'b1);
        tick(); es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_0000; #1;
        chk("lhu_offer",  79'(ms_to_ws_valid),      79'(1));
        chk("lhu_result", 79'(ms_to_ws_bus[63:32]), 79'(32'h0000_8001));
        tick(); data_sram_data_ok = 1'b0; data_sram_rdata = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lhu_hold_valid", 79'(ms_to_ws_valid),      79'(1));
            chk("lhu_hold_res",   79'(ms_to_ws_bus[63:32]), 79'(32'h0000_8001));
            tick();
        end
        ws_allowin = 1'b1; #1;
        chk("lhu_emit",     79'(ms_to_ws_valid),      79'(1));
        chk("lhu_emit_res", 79'(ms_to_ws_bus[63:32]), 79'(32'h0000_8001));
        tick(); #1 chk("lhu_once", 79'(ms_to_ws_valid), 79'(0));

        // flush during WAIT: stale response discarded, the next lw gets its own data
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(6'b0, 4'hF, 5'd2, 32'h0000_0100, 32'hBFC0_000C, 3'd5, 1'b1);
        tick(); es_to_ms_valid = 1'b0; flush = 1'b1;
        #1 chk("fl_flushed", 79'(ms_to_ws_valid), 79'(0));
        tick(); flush = 1'b0; es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(6'b0, 4'hF, 5'd3, 32'h0000_3000, 32'hBFC0_0010, 3'd5, 1'b1);
        #1 chk("fl_allowin", 79'(ms_allowin), 79'(1));
        tick(); es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD;
        #1 chk("fl_discard", 79'(ms_to_ws_valid), 79'(0));
        tick(); data_sram_data_ok = 1'b0;
        #1 chk("fl_wait", 79'(ms_to_ws_valid), 79'(0));
        tick(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF; #1;
        chk("fl_valid",  79'(ms_to_ws_valid),      79'(1));
        chk("fl_result", 79'(ms_to_ws_bus[63:32]), 79'(32'hBEEF));
        tick(); data_sram_data_ok = 1'b0;

        // flush in the same cycle as an offered entry drops it
        es_to_ms_valid = 1'b1; flush = 1'b1;
        es_to_ms_bus = mk(6'b0, 4'hF, 5'd4, 32'h55, 32'hBFC0_0014, 3'd0, 1'b0);
        tick(); es_to_ms_valid = 1'b0; flush = 1'b0; #1;
        chk("drop_valid",   79'(ms_to_ws_valid), 79'(0));
        chk("drop_allowin", 79'(ms_allowin),     79'(1));
        chk("drop_dest",    79'(ms_rf_dest),     79'(0));

        // reset during WAIT, then a stale response
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk(6'b000010, 4'hF, 5'd6, 32'h0000_0200, 32'hBFC0_0018, 3'd5, 1'b1);
        tick(); es_to_ms_valid = 1'b0; resetn = 1'b0;
        tick(); resetn = 1'b1;
        tick(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE; #1;
        chk("stale_flag",    79'(dut.proto_err_c),  79'(1));
        chk("stale_valid",   79'(ms_to_ws_valid),   79'(0));
        chk("stale_allowin", 79'(ms_allowin),       79'(1));
        chk("stale_dest",    79'(ms_rf_dest),       79'(0));
        chk("stale_mfc0",    79'(ms_inst_mfc0_o),   79'(0));
        tick(); data_sram_data_ok = 1'b0;
        #1 chk("stale_after", 79'(ms_to_ws_valid), 79'(0));

        // randomized traffic against a one-slot transaction model with a responding memory
        m_valid = 1'b0; m_have = 1'b0; pend = 1'b0; dly = 0; m_bus = '0; m_final = '0;
        for (int c = 0; c < 600; c++) begin
            ws_allowin     = ($urandom_range(0, 3) != 0);
            es_to_ms_valid = 1'($urandom_range(0, 1));
            r_req          = 1'($urandom_range(0, 1));
            r_op           = r_req ? 3'($urandom_range(0, 7)) : 3'd0;
            es_to_ms_bus   = mk(6'($urandom), 4'($urandom), 5'($urandom), $urandom, $urandom,
                                r_op, r_req);
            data_sram_data_ok = pend && (dly == 0);
            data_sram_rdata   = $urandom;
            #1;
            if (data_sram_data_ok) begin
                m_have  = 1'b1;
                m_final = ld_result(m_bus[3:1], m_bus[67:36], data_sram_rdata);
            end
            ev = m_valid && (!m_bus[0] || m_have);
            ea = !m_valid || (ev && ws_allowin);
            chk("rnd_valid",   79'(ms_to_ws_valid), 79'(ev));
            chk("rnd_allowin", 79'(ms_allowin),     79'(ea));
            chk("rnd_dest",    79'(ms_rf_dest),
                79'((m_valid && m_bus[76:73] != 4'd0) ? m_bus[72:68] : 5'd0));
            chk("rnd_mfc0",    79'(ms_inst_mfc0_o), 79'(m_valid && m_bus[78]));
            if (ev) begin
                fin = m_bus[0] ? m_final : m_bus[67:36];
                chk("rnd_bus", ms_to_ws_bus, out_bus(m_bus, fin));
            end
            if (data_sram_data_ok) pend = 1'b0;
            else if (pend) dly--;
            if (ev && ws_allowin) m_valid = 1'b0;
            if (es_to_ms_valid && ea) begin
                m_valid = 1'b1;
                m_bus   = es_to_ms_bus;
                m_have  = 1'b0;
                if (r_req) begin
                    pend = 1'b1;
                    dly  = $urandom_range(0, 3);
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
